// File: rtl/rr_arb16.sv
// 16-way round-robin arbiter with a bounded hold time.
// Grant is kept as a registered 4-bit index and decoded to a one-hot vector.
module rr_arb16 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_vld
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               TIMEOUT_EN = (HOLD_MAX != 0);

  state_t           state, state_nxt;
  logic [3:0]       ptr, ptr_nxt;
  logic [3:0]       idx_nxt;
  logic             vld_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [4:0]       pick;
  logic             release_now;

  // Scan from the highest offset down so the lowest offset from start wins.
  function automatic logic [4:0] pick_next(input logic [15:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = start + 4'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  assign pick = pick_next(req, ptr);

  assign release_now = done || !req[gnt_idx] ||
                       (TIMEOUT_EN && (hold_cnt == HOLD_LIM));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick[4]) begin
          state_nxt = GRANT;
          idx_nxt   = pick[3:0];
          vld_nxt   = 1'b1;
          hold_nxt  = CNT_ONE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          hold_nxt  = '0;
          ptr_nxt   = gnt_idx + 4'd1;
        end else begin
          hold_nxt  = sat_inc(hold_cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      gnt_vld  <= vld_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // One-hot decode of the registered index, so reset clears it immediately.
  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16: expected grants are queued as stimulus is
// driven and compared one cycle later when the arbiter produces them.
module tb_rr_arb16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_arb16 #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk_exp(input logic [3:0] idx, input logic vld);
    exp_t e;
    e.idx = idx;
    e.vld = vld;
    e.gnt = vld ? (16'h0001 << idx) : 16'h0000;
    return e;
  endfunction

  // Leaves the bench between clock edges with the arbiter freshly reset.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #2;
    exp_q.push_back(mk_exp(4'd0, 1'b0));
    e = exp_q.pop_front();
    n_cmp++;
    if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
      n_bad++;
      $display("FAIL reset_init: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
               gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
    end
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0, 1: begin req = 16'h0010; done = 1'b0; exp_q.push_back(mk_exp(4'd4, 1'b1)); end
        2:    begin req = 16'h0001; done = 1'b0; exp_q.push_back(mk_exp(4'd0, 1'b1)); end
        default: begin req = 16'h0001; done = 1'b1; exp_q.push_back(mk_exp(4'd0, 1'b0)); end
      endcase
      if (k == 2) begin
        // Mid-cycle reset during the grant to requester 4: no clock edge involved.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_front(mk_exp(4'd0, 1'b0));
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
          n_bad++;
          $display("FAIL reset_async: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                   gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
        end
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL reset[%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] t_req  [5] = '{16'h0400, 16'h0400, 16'h0C01, 16'h0C01, 16'h0C01};
    logic        t_done [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_idx  [5] = '{4'd10, 4'd10, 4'd11, 4'd11, 4'd0};
    logic        t_vld  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req  = t_req[k];
      done = t_done[k];
      exp_q.push_back(mk_exp(t_idx[k], t_vld[k]));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL single[%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k < 34; k++) begin
      done = k[0];
      exp_q.push_back(mk_exp(4'((k / 2) % 16), ~k[0]));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL rotation[%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] t_req  [5] = '{16'h4000, 16'h4000, 16'h8001, 16'h8001, 16'h8001};
    logic        t_done [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_idx  [5] = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd0};
    logic        t_vld  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req  = t_req[k];
      done = t_done[k];
      exp_q.push_back(mk_exp(t_idx[k], t_vld[k]));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    req  = 16'h0006;
    done = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c <= 8)       exp_q.push_back(mk_exp(4'd1, 1'b1));
      else if (c == 9)  exp_q.push_back(mk_exp(4'd1, 1'b0));
      else if (c <= 17) exp_q.push_back(mk_exp(4'd2, 1'b1));
      else if (c == 18) exp_q.push_back(mk_exp(4'd2, 1'b0));
      else              exp_q.push_back(mk_exp(4'd1, 1'b1));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL timeout[cyc%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 c, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_withdraw();
    logic [15:0] t_req  [11] = '{16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0018,
                                 16'h0008, 16'h0008, 16'h000C, 16'h000C, 16'h000C};
    logic        t_done [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_idx  [11] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4,
                                 4'd4, 4'd3, 4'd3, 4'd3, 4'd2};
    logic        t_vld  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      req  = t_req[k];
      done = t_done[k];
      exp_q.push_back(mk_exp(t_idx[k], t_vld[k]));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_vld !== e.vld) begin
        n_bad++;
        $display("FAIL withdraw[%0d]: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                 k, gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
